// File: rtl/rob_dual_commit.sv
`default_nettype none
// ============================================================================
// rob_dual_commit : reorder buffer with two-wide in-order commit, CDB bypass
//                   on operand query and redirect/flush on jump or taken branch
// Revision        : 1.0
// ============================================================================
module rob_dual_commit #(
  parameter int DEPTH         = 16,
  parameter int ID_W          = 4,
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int REG_W         = 5,
  parameter int FULL_MARGIN   = 3,
  parameter int OP_TYPE_WIDTH = 3,
  parameter logic [OP_TYPE_WIDTH-1:0] OP_ARITH  = 3'd0,
  parameter logic [OP_TYPE_WIDTH-1:0] OP_JUMP   = 3'd1,
  parameter logic [OP_TYPE_WIDTH-1:0] OP_LOAD   = 3'd2,
  parameter logic [OP_TYPE_WIDTH-1:0] OP_STORE  = 3'd3,
  parameter logic [OP_TYPE_WIDTH-1:0] OP_BRANCH = 3'd4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     dp_valid_in,
  input  logic [OP_TYPE_WIDTH-1:0] dp_op_type_in,
  input  logic [REG_W-1:0]         dp_dest_in,
  output logic                     dp_full_out,
  output logic [ID_W-1:0]          dp_rob_id_out,
  input  logic [ID_W-1:0]          dp_rs1_id_in,
  input  logic [ID_W-1:0]          dp_rs2_id_in,
  output logic                     dp_rs1_rdy_out,
  output logic                     dp_rs2_rdy_out,
  output logic [DATA_W-1:0]        dp_rs1_val_out,
  output logic [DATA_W-1:0]        dp_rs2_val_out,
  input  logic                     a_valid_in,
  input  logic [ID_W-1:0]          a_rob_id_in,
  input  logic [DATA_W-1:0]        a_result_in,
  input  logic [ADDR_W-1:0]        a_new_pc_in,
  input  logic                     ls_valid_in,
  input  logic [ID_W-1:0]          ls_rob_id_in,
  input  logic [DATA_W-1:0]        ls_result_in,
  output logic                     rf_we0_out,
  output logic                     rf_we1_out,
  output logic [REG_W-1:0]         rf_dest0_out,
  output logic [REG_W-1:0]         rf_dest1_out,
  output logic [DATA_W-1:0]        rf_val0_out,
  output logic [DATA_W-1:0]        rf_val1_out,
  output logic [ID_W-1:0]          rf_id0_out,
  output logic [ID_W-1:0]          rf_id1_out,
  output logic [ID_W-1:0]          lsb_head_id_out,
  output logic                     flush_out,
  output logic [ADDR_W-1:0]        flush_pc_out
);

  localparam logic [ID_W-1:0] c_FIRST_ID = ID_W'(1);
  localparam logic [ID_W-1:0] c_LAST_ID  = ID_W'(DEPTH - 1);
  localparam logic [ID_W:0]   c_CNT_ONE  = (ID_W+1)'(1);
  localparam logic [ID_W:0]   c_FULL_LVL = (ID_W+1)'(DEPTH - 1 - FULL_MARGIN);

  logic [OP_TYPE_WIDTH-1:0] r_op   [DEPTH];
  logic [REG_W-1:0]         r_dest [DEPTH];
  logic [DATA_W-1:0]        r_val  [DEPTH];
  logic [ADDR_W-1:0]        r_pc   [DEPTH];
  logic [DEPTH-1:0]         r_rdy;
  logic [ID_W-1:0]          r_head;
  logic [ID_W-1:0]          r_tail;
  logic [ID_W:0]            r_count;

  logic            w_dp;
  logic [ID_W-1:0] w_h1;
  logic            w_c0, w_c1, w_redir0, w_redir1, w_wb0, w_wb1;
  logic [1:0]      w_n_commit;
  logic [ID_W:0]   w_count_nxt;
  logic            w_rs1_a, w_rs1_ls, w_rs2_a, w_rs2_ls;

  function automatic logic [ID_W-1:0] f_next(input logic [ID_W-1:0] id);
    return (id == c_LAST_ID) ? c_FIRST_ID : id + c_FIRST_ID;
  endfunction

  function automatic logic f_writes_rf(input logic [OP_TYPE_WIDTH-1:0] op,
                                       input logic [REG_W-1:0] dest);
    return ((op == OP_ARITH) || (op == OP_JUMP) || (op == OP_LOAD)) && (dest != '0);
  endfunction

  assign dp_full_out     = (r_count >= c_FULL_LVL);
  assign dp_rob_id_out   = r_tail;
  assign lsb_head_id_out = r_head;
  assign w_dp            = dp_valid_in && !flush_out && !dp_full_out;

  // Second commit slot is blocked behind a redirecting first slot.
  assign w_h1       = f_next(r_head);
  assign w_c0       = (r_count != '0) && r_rdy[r_head];
  assign w_redir0   = (r_op[r_head] == OP_JUMP) ||
                      ((r_op[r_head] == OP_BRANCH) && r_val[r_head][0]);
  assign w_c1       = w_c0 && !w_redir0 && (r_count > c_CNT_ONE) && r_rdy[w_h1];
  assign w_redir1   = (r_op[w_h1] == OP_JUMP) ||
                      ((r_op[w_h1] == OP_BRANCH) && r_val[w_h1][0]);
  assign w_wb0      = f_writes_rf(r_op[r_head], r_dest[r_head]);
  assign w_wb1      = f_writes_rf(r_op[w_h1], r_dest[w_h1]);
  assign w_n_commit = {1'b0, w_c0} + {1'b0, w_c1};
  assign w_count_nxt = r_count + (ID_W+1)'(w_dp) - (ID_W+1)'(w_n_commit);

  assign w_rs1_a  = a_valid_in && (a_rob_id_in == dp_rs1_id_in);
  assign w_rs1_ls = ls_valid_in && (ls_rob_id_in == dp_rs1_id_in) &&
                    ((r_op[dp_rs1_id_in] == OP_LOAD) || (r_op[dp_rs1_id_in] == OP_STORE));
  assign w_rs2_a  = a_valid_in && (a_rob_id_in == dp_rs2_id_in);
  assign w_rs2_ls = ls_valid_in && (ls_rob_id_in == dp_rs2_id_in) &&
                    ((r_op[dp_rs2_id_in] == OP_LOAD) || (r_op[dp_rs2_id_in] == OP_STORE));

  assign dp_rs1_rdy_out = r_rdy[dp_rs1_id_in] | w_rs1_a | w_rs1_ls;
  assign dp_rs2_rdy_out = r_rdy[dp_rs2_id_in] | w_rs2_a | w_rs2_ls;
  assign dp_rs1_val_out = w_rs1_a ? a_result_in : (w_rs1_ls ? ls_result_in : r_val[dp_rs1_id_in]);
  assign dp_rs2_val_out = w_rs2_a ? a_result_in : (w_rs2_ls ? ls_result_in : r_val[dp_rs2_id_in]);

  // Payload storage carries no reset; rdy bits gate every use of it.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && rdy_in && !flush_out) begin
      if (w_dp) begin
        r_op[r_tail]   <= dp_op_type_in;
        r_dest[r_tail] <= dp_dest_in;
      end
      if (a_valid_in) begin
        r_val[a_rob_id_in] <= a_result_in;
        r_pc[a_rob_id_in]  <= a_new_pc_in;
      end
      if (ls_valid_in && (r_op[ls_rob_id_in] == OP_LOAD))
        r_val[ls_rob_id_in] <= ls_result_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_head       <= c_FIRST_ID;
      r_tail       <= c_FIRST_ID;
      r_count      <= '0;
      r_rdy        <= '0;
      rf_we0_out   <= 1'b0;
      rf_we1_out   <= 1'b0;
      rf_dest0_out <= '0;
      rf_dest1_out <= '0;
      rf_val0_out  <= '0;
      rf_val1_out  <= '0;
      rf_id0_out   <= '0;
      rf_id1_out   <= '0;
      flush_out    <= 1'b0;
      flush_pc_out <= '0;
    end else if (rdy_in) begin
      if (flush_out) begin
        r_head     <= c_FIRST_ID;
        r_tail     <= c_FIRST_ID;
        r_count    <= '0;
        r_rdy      <= '0;
        rf_we0_out <= 1'b0;
        rf_we1_out <= 1'b0;
        flush_out  <= 1'b0;
      end else begin
        rf_we0_out   <= w_c0 && w_wb0;
        rf_we1_out   <= w_c1 && w_wb1;
        rf_dest0_out <= r_dest[r_head];
        rf_dest1_out <= r_dest[w_h1];
        rf_val0_out  <= r_val[r_head];
        rf_val1_out  <= r_val[w_h1];
        rf_id0_out   <= r_head;
        rf_id1_out   <= w_h1;
        if (w_c1)
          r_head <= f_next(w_h1);
        else if (w_c0)
          r_head <= w_h1;
        if (w_dp)
          r_tail <= f_next(r_tail);
        r_count <= w_count_nxt;
        if (w_c0 && w_redir0) begin
          flush_out    <= 1'b1;
          flush_pc_out <= r_pc[r_head];
        end else if (w_c1 && w_redir1) begin
          flush_out    <= 1'b1;
          flush_pc_out <= r_pc[w_h1];
        end
        if (w_dp)
          r_rdy[r_tail] <= 1'b0;
        if (a_valid_in)
          r_rdy[a_rob_id_in] <= 1'b1;
        if (ls_valid_in)
          r_rdy[ls_rob_id_in] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_dual_commit.sv
`default_nettype none
// Bench for rob_dual_commit: directed stimulus, commit/flush scoreboard with decoupled monitor.
module tb_rob_dual_commit;
  localparam logic [2:0] ARITH = 3'd0, JUMP = 3'd1, LOAD = 3'd2, BRANCH = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic        dp_valid;
  logic [2:0]  dp_op;
  logic [4:0]  dp_dest;
  logic        dp_full;
  logic [3:0]  dp_id;
  logic [3:0]  rs1_id, rs2_id;
  logic        rs1_rdy, rs2_rdy;
  logic [31:0] rs1_val, rs2_val;
  logic        a_valid;
  logic [3:0]  a_id;
  logic [31:0] a_res, a_pc;
  logic        ls_valid;
  logic [3:0]  ls_id;
  logic [31:0] ls_res;
  logic        we0, we1;
  logic [4:0]  dest0, dest1;
  logic [31:0] val0, val1;
  logic [3:0]  id0, id1;
  logic [3:0]  head_id;
  logic        flush;
  logic [31:0] flush_pc;

  rob_dual_commit dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .dp_valid_in(dp_valid), .dp_op_type_in(dp_op), .dp_dest_in(dp_dest),
    .dp_full_out(dp_full), .dp_rob_id_out(dp_id),
    .dp_rs1_id_in(rs1_id), .dp_rs2_id_in(rs2_id),
    .dp_rs1_rdy_out(rs1_rdy), .dp_rs2_rdy_out(rs2_rdy),
    .dp_rs1_val_out(rs1_val), .dp_rs2_val_out(rs2_val),
    .a_valid_in(a_valid), .a_rob_id_in(a_id), .a_result_in(a_res), .a_new_pc_in(a_pc),
    .ls_valid_in(ls_valid), .ls_rob_id_in(ls_id), .ls_result_in(ls_res),
    .rf_we0_out(we0), .rf_we1_out(we1), .rf_dest0_out(dest0), .rf_dest1_out(dest1),
    .rf_val0_out(val0), .rf_val1_out(val1), .rf_id0_out(id0), .rf_id1_out(id1),
    .lsb_head_id_out(head_id), .flush_out(flush), .flush_pc_out(flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        slot;
    logic [4:0]  dest;
    logic [31:0] val;
    logic [3:0]  id;
  } commit_t;

  commit_t     cq[$];
  logic [31:0] fq[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic upd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_c(input logic slot, input logic [4:0] d, input logic [31:0] v, input logic [3:0] id);
    commit_t e;
    e.slot = slot; e.dest = d; e.val = v; e.id = id;
    cq.push_back(e);
  endtask

  task automatic mon_commit(input logic slot, input logic [4:0] d, input logic [31:0] v, input logic [3:0] id);
    commit_t e;
    n_cmp++;
    if (cq.size() == 0) begin
      n_bad++;
      $display("FAIL commit: unexpected slot%0d dest %0d val %0h id %0d", slot, d, v, id);
    end else begin
      e = cq.pop_front();
      if (e.slot !== slot || e.dest !== d || e.val !== v || e.id !== id) begin
        n_bad++;
        $display("FAIL commit: got slot%0d dest %0d val %0h id %0d want slot%0d dest %0d val %0h id %0d",
                 slot, d, v, id, e.slot, e.dest, e.val, e.id);
      end
    end
  endtask

  // Registered outputs only carry a new event after an edge with the enable high.
  always @(posedge clk) upd <= rst_n && rdy;

  always @(negedge clk) begin
    if (upd) begin
      if (we0) mon_commit(1'b0, dest0, val0, id0);
      if (we1) mon_commit(1'b1, dest1, val1, id1);
      if (flush) begin
        n_cmp++;
        if (fq.size() == 0) begin
          n_bad++;
          $display("FAIL flush: unexpected pc %0h", flush_pc);
        end else begin
          logic [31:0] p;
          p = fq.pop_front();
          if (flush_pc !== p) begin
            n_bad++;
            $display("FAIL flush: got pc %0h want %0h", flush_pc, p);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [2:0] op, input logic [4:0] d, input logic [3:0] exp_id);
    dp_valid = 1'b1; dp_op = op; dp_dest = d;
    #1 chk("dispatch_id", 32'(dp_id), 32'(exp_id));
    tick();
    dp_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; dp_valid = 1'b0; dp_op = ARITH; dp_dest = '0;
    rs1_id = '0; rs2_id = '0; a_valid = 1'b0; a_id = '0; a_res = '0; a_pc = '0;
    ls_valid = 1'b0; ls_id = '0; ls_res = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_tail", 32'(dp_id), 32'd1);
    chk("rst_head", 32'(head_id), 32'd1);
    chk("rst_full", 32'(dp_full), 32'd0);
    chk("rst_we", {30'd0, we1, we0}, 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_flush_pc", flush_pc, 32'd0);

    // Three dispatches, then out-of-order results and a dual commit
    dispatch(ARITH, 5'd5, 4'd1);
    dispatch(ARITH, 5'd6, 4'd2);
    dispatch(LOAD,  5'd7, 4'd3);
    chk("tail_after3", 32'(dp_id), 32'd4);
    chk("full_after3", 32'(dp_full), 32'd0);
    a_valid = 1'b1; a_id = 4'd2; a_res = 32'h22; a_pc = '0;
    tick();
    a_id = 4'd1; a_res = 32'h11;
    ls_valid = 1'b1; ls_id = 4'd3; ls_res = 32'h33;
    rs1_id = 4'd3; rs2_id = 4'd2;
    #1;
    chk("ls_bypass_rdy", 32'(rs1_rdy), 32'd1);
    chk("ls_bypass_val", rs1_val, 32'h33);
    chk("stored_rdy", 32'(rs2_rdy), 32'd1);
    chk("stored_val", rs2_val, 32'h22);
    push_c(1'b0, 5'd5, 32'h11, 4'd1);
    push_c(1'b1, 5'd6, 32'h22, 4'd2);
    push_c(1'b0, 5'd7, 32'h33, 4'd3);
    tick();
    a_valid = 1'b0; ls_valid = 1'b0;
    tick(); tick(); tick();
    chk("head_after_drain", 32'(head_id), 32'd4);

    // Fill to the full threshold, wrap the tail, release through commit
    for (int k = 0; k < 12; k++) begin
      chk("not_full", 32'(dp_full), 32'd0);
      dispatch(ARITH, 5'(4 + k), 4'(4 + k));
    end
    chk("full_at_12", 32'(dp_full), 32'd1);
    chk("tail_wrap", 32'(dp_id), 32'd1);
    rs1_id = 4'd4;
    #1 chk("q_not_rdy", 32'(rs1_rdy), 32'd0);
    a_valid = 1'b1; a_id = 4'd4; a_res = 32'hAB; a_pc = '0;
    #1;
    chk("alu_bypass_rdy", 32'(rs1_rdy), 32'd1);
    chk("alu_bypass_val", rs1_val, 32'hAB);
    push_c(1'b0, 5'd4, 32'hAB, 4'd4);
    tick();
    a_valid = 1'b0;
    chk("full_before_commit", 32'(dp_full), 32'd1);
    tick();
    chk("full_after_commit", 32'(dp_full), 32'd0);
    chk("head_after_id4", 32'(head_id), 32'd5);
    dispatch(ARITH, 5'd1, 4'd1);
    for (int id = 5; id < 16; id++) begin
      a_valid = 1'b1; a_id = 4'(id); a_res = 32'(256 + id);
      push_c(1'b0, 5'(id), 32'(256 + id), 4'(id));
      tick();
    end
    a_id = 4'd1; a_res = 32'h1111;
    push_c(1'b0, 5'd1, 32'h1111, 4'd1);
    tick();
    a_valid = 1'b0;
    tick(); tick(); tick();
    chk("head_wrapped", 32'(head_id), 32'd2);

    // Taken branch redirect blocks the ready younger entry
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    dispatch(BRANCH, 5'd0, 4'd1);
    dispatch(ARITH,  5'd9, 4'd2);
    a_valid = 1'b1; a_id = 4'd2; a_res = 32'h99; a_pc = '0;
    tick();
    a_id = 4'd1; a_res = 32'h1; a_pc = 32'h1000;
    fq.push_back(32'h1000);
    tick();
    a_valid = 1'b0;
    tick();
    chk("flush_set", 32'(flush), 32'd1);
    chk("flush_pc", flush_pc, 32'h1000);
    dp_valid = 1'b1; dp_op = ARITH; dp_dest = 5'd4;
    a_valid = 1'b1; a_id = 4'd3; a_res = 32'h77;
    tick();
    dp_valid = 1'b0; a_valid = 1'b0;
    rs1_id = 4'd2; rs2_id = 4'd3;
    #1;
    chk("flush_clear", 32'(flush), 32'd0);
    chk("flush_tail", 32'(dp_id), 32'd1);
    chk("flush_head", 32'(head_id), 32'd1);
    chk("flush_rdy_cleared", 32'(rs1_rdy), 32'd0);
    chk("flush_cdb_ignored", 32'(rs2_rdy), 32'd0);

    // Stall across a pending jump commit, then reset while flush is held
    dispatch(JUMP, 5'd3, 4'd1);
    a_valid = 1'b1; a_id = 4'd1; a_res = 32'h2004; a_pc = 32'h3000;
    tick();
    a_valid = 1'b0; rdy = 1'b0; dp_valid = 1'b1; dp_op = ARITH; dp_dest = 5'd8;
    tick(); tick(); tick();
    dp_valid = 1'b0;
    chk("stall_we0", 32'(we0), 32'd0);
    chk("stall_flush", 32'(flush), 32'd0);
    chk("stall_head", 32'(head_id), 32'd1);
    chk("stall_tail", 32'(dp_id), 32'd2);
    rdy = 1'b1;
    push_c(1'b0, 5'd3, 32'h2004, 4'd1);
    fq.push_back(32'h3000);
    tick();
    rdy = 1'b0;
    tick(); tick();
    chk("flush_held", 32'(flush), 32'd1);
    chk("flush_pc_held", flush_pc, 32'h3000);
    rst_n = 1'b0;
    tick();
    chk("rst_over_flush", 32'(flush), 32'd0);
    chk("rst_flush_pc2", flush_pc, 32'd0);
    chk("rst_tail2", 32'(dp_id), 32'd1);
    rst_n = 1'b1; rdy = 1'b1;

    for (int i = 0; i < 20 && (cq.size() != 0 || fq.size() != 0); i++) tick();
    chk("commit_queue_empty", 32'(cq.size()), 32'd0);
    chk("flush_queue_empty", 32'(fq.size()), 32'd0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
